alu_4bit: RTL and testbench

- 4-bit registered ALU slice; core datapath behind the `alu` wrapper.
- The wrapper applies optional d2 inversion (b_inv) before this block, so d2 arrives here already conditioned.
- Operations: carry-lookahead add, carry-free XOR, AND, OR, and a 1-bit right shift with carry_in as fill.
- One result per cycle, 1-cycle latency.

---
 rtl/alu_4bit.sv | 114 +++++++++++
 tb/tb_alu_4bit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu_4bit.sv
// alu_4bit: 4-bit registered ALU slice (add/xor, and, or, shift right).
// Every operation produces its result one clock after in_valid is sampled.
// Optional feature macro: ALU4_ALL_ONES_FLAG_EN adds a registered
// res_all_ones output that is 1 when the registered result equals 4'hF.
module alu_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic       carry_in,
  input  logic       carry_disable,
  input  logic [1:0] cmd,
  output logic       out_valid,
  output logic [3:0] res,
  output logic       carry_out
`ifdef ALU4_ALL_ONES_FLAG_EN
  ,
  output logic       res_all_ones
`endif
);

  typedef enum logic [1:0] {
    CMD_ADD = 2'b00,
    CMD_AND = 2'b01,
    CMD_OR  = 2'b10,
    CMD_SHR = 2'b11
  } cmd_e;

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  logic       carry_en;
  logic [3:0] res_d;
  logic       carry_d;
  logic [3:0] res_q;
  logic       carry_q;
  logic       valid_q;

  // Generate/propagate terms and flat two-level lookahead carries.
  // A single enable masks every carry, so carry_disable turns the
  // adder into a plain XOR of the operands.
  always_comb begin
    g        = d1 & d2;
    p        = d1 ^ d2;
    carry_en = ~carry_disable;
    c[0] = carry_in & carry_en;
    c[1] = carry_en & (g[0] | (p[0] & carry_in));
    c[2] = carry_en & (g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry_in));
    c[3] = carry_en & (g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                      | (p[2] & p[1] & p[0] & carry_in));
    c[4] = carry_en & (g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                      | (p[3] & p[2] & p[1] & g[0])
                      | (p[3] & p[2] & p[1] & p[0] & carry_in));
  end

  // Select the result and flag bit for the requested operation.
  always_comb begin
    res_d   = 4'h0;
    carry_d = 1'b0;
    case (cmd_e'(cmd))
      CMD_ADD: begin
        res_d   = p ^ c[3:0];
        carry_d = c[4];
      end
      CMD_AND: res_d = d1 & d2;
      CMD_OR:  res_d = d1 | d2;
      CMD_SHR: begin
        // carry_in fills the vacated MSB; the LSB falls out as the flag.
        res_d   = {carry_in, d2[3:1]};
        carry_d = d2[0];
      end
      default: begin
        res_d   = 4'h0;
        carry_d = 1'b0;
      end
    endcase
  end

  // Result registers: load on valid input, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= 4'h0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        res_q   <= res_d;
        carry_q <= carry_d;
      end
    end
  end

  assign out_valid = valid_q;
  assign res       = res_q;
  assign carry_out = carry_q;

`ifdef ALU4_ALL_ONES_FLAG_EN
  logic ones_q;

  // All-ones flag registered alongside the result (equality flag for COMP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_q <= 1'b0;
    end else if (in_valid) begin
      ones_q <= &res_d;
    end
  end

  assign res_all_ones = ones_q;
`endif

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: the driver pushes the expected response per
// issued cycle, a negedge monitor pops and compares whenever a result is due.
module tb_alu_4bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] d1;
  logic [3:0] d2;
  logic       carry_in;
  logic       carry_disable;
  logic [1:0] cmd;
  logic       out_valid;
  logic [3:0] res;
  logic       carry_out;
`ifdef ALU4_ALL_ONES_FLAG_EN
  logic       res_all_ones;
`endif

  alu_4bit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .d1           (d1),
    .d2           (d2),
    .carry_in     (carry_in),
    .carry_disable(carry_disable),
    .cmd          (cmd),
    .out_valid    (out_valid),
    .res          (res),
    .carry_out    (carry_out)
`ifdef ALU4_ALL_ONES_FLAG_EN
    ,
    .res_all_ones (res_all_ones)
`endif
  );

  typedef struct {
    string      name;
    logic [3:0] res;
    logic       co;
  } exp_t;

  exp_t exp_q[$];
  bit   vld_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [3:0] held_res = 4'h0;
  logic       held_co  = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, want);
    end
  endtask

  // Reference from the arithmetic definitions of each operation.
  function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b,
                                       input logic ci, input logic cd,
                                       input logic [1:0] op);
    logic [4:0] s;
    case (op)
      2'b00: s = cd ? {1'b0, a ^ b} : ({1'b0, a} + {1'b0, b} + {4'b0, ci});
      2'b01: s = {1'b0, a & b};
      2'b10: s = {1'b0, a | b};
      default: s = {b[0], ci, b[3:1]};
    endcase
    return s;
  endfunction

  // Drive one cycle (called at posedge+1), then record what is due next.
  task automatic issue(input string nm, input logic v, input logic [3:0] a,
                       input logic [3:0] b, input logic ci, input logic cd,
                       input logic [1:0] op, input logic [3:0] er, input logic eco);
    exp_t e;
    in_valid = v; d1 = a; d2 = b; carry_in = ci; carry_disable = cd; cmd = op;
    @(posedge clk);
    vld_q.push_back(v);
    if (v) begin
      e.name = nm; e.res = er; e.co = eco;
      exp_q.push_back(e);
    end
    #1;
  endtask

  // Monitor: one line per transaction, compared against the scoreboard.
  always @(negedge clk) begin
    if (vld_q.size() > 0) begin
      bit v;
      v = vld_q.pop_front();
      chk("out_valid", {3'b0, out_valid}, {3'b0, v});
      if (v && exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, ".res"}, res, e.res);
        chk({e.name, ".carry_out"}, {3'b0, carry_out}, {3'b0, e.co});
`ifdef ALU4_ALL_ONES_FLAG_EN
        chk({e.name, ".all_ones"}, {3'b0, res_all_ones}, {3'b0, (e.res == 4'hF)});
`endif
        held_res = e.res;
        held_co  = e.co;
        if (e.name.substr(0, 3) != "exh_")
          $display("txn %s: res=%h carry_out=%b", e.name, res, carry_out);
      end else if (!v) begin
        chk("hold.res", res, held_res);
        chk("hold.carry_out", {3'b0, carry_out}, {3'b0, held_co});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    logic [4:0] m;
    rst_n = 1'b0; in_valid = 1'b0; d1 = 4'h0; d2 = 4'h0;
    carry_in = 1'b0; carry_disable = 1'b0; cmd = 2'b00;
    #1;
    chk("reset.res", res, 4'h0);
    chk("reset.carry_out", {3'b0, carry_out}, 4'h0);
    chk("reset.out_valid", {3'b0, out_valid}, 4'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    issue("add_9_8",   1, 4'h9, 4'h8, 0, 0, 2'b00, 4'h1, 1);
    issue("add_3_4",   1, 4'h3, 4'h4, 0, 0, 2'b00, 4'h7, 0);
    issue("sub_5_3",   1, 4'h5, 4'hC, 1, 0, 2'b00, 4'h2, 1);
    issue("sub_3_5",   1, 4'h3, 4'hA, 1, 0, 2'b00, 4'hE, 0);
    issue("cmp_7_7",   1, 4'h7, 4'h8, 0, 0, 2'b00, 4'hF, 0);
    issue("cmp_9_4",   1, 4'h9, 4'hB, 0, 0, 2'b00, 4'h4, 1);
    issue("xor_c_a",   1, 4'hC, 4'hA, 1, 1, 2'b00, 4'h6, 0);
    issue("and_c_a",   1, 4'hC, 4'hA, 1, 0, 2'b01, 4'h8, 0);
    issue("or_c_a",    1, 4'hC, 4'hA, 1, 0, 2'b10, 4'hE, 0);
    issue("shr_b_c1",  1, 4'h0, 4'hB, 1, 0, 2'b11, 4'hD, 1);
    issue("shr_b_c0",  1, 4'h7, 4'hB, 0, 0, 2'b11, 4'h5, 1);
    issue("shr_b_cd",  1, 4'h3, 4'hB, 1, 1, 2'b11, 4'hD, 1);
    issue("add_f_1",   1, 4'hF, 4'h1, 0, 0, 2'b00, 4'h0, 1);
    issue("add_f_f_c", 1, 4'hF, 4'hF, 1, 0, 2'b00, 4'hF, 1);
    issue("shl_6_6",   1, 4'h6, 4'h6, 0, 0, 2'b00, 4'hC, 0);

    // Alternate-cycle valid pulses; idle cycles carry junk inputs.
    issue("hs_a",  1, 4'h2, 4'h5, 0, 0, 2'b00, 4'h7, 0);
    issue("idle",  0, 4'hF, 4'hF, 1, 0, 2'b00, 4'h0, 0);
    issue("hs_b",  1, 4'h6, 4'h3, 0, 0, 2'b01, 4'h2, 0);
    issue("idle",  0, 4'h8, 4'h9, 1, 0, 2'b11, 4'h0, 0);
    issue("hs_c",  1, 4'h0, 4'h3, 0, 0, 2'b11, 4'h1, 1);
    issue("idle",  0, 4'h1, 4'h1, 0, 0, 2'b10, 4'h0, 0);

    // Reset right after a result is registered, before it is consumed.
    issue("pre_rst", 1, 4'hA, 4'hA, 0, 0, 2'b10, 4'hA, 0);
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    exp_q.delete(); vld_q.delete();
    held_res = 4'h0; held_co = 1'b0;
    chk("midrst.res", res, 4'h0);
    chk("midrst.carry_out", {3'b0, carry_out}, 4'h0);
    chk("midrst.out_valid", {3'b0, out_valid}, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    issue("idle_after_rst", 0, 4'h5, 4'h5, 0, 0, 2'b00, 4'h0, 0);
    issue("post_rst", 1, 4'h5, 4'h5, 1, 0, 2'b00, 4'hB, 0);

    // Exhaustive sweep against the arithmetic model.
    for (int op = 0; op < 4; op++)
      for (int cc = 0; cc < 4; cc++)
        for (int a = 0; a < 16; a++)
          for (int b = 0; b < 16; b++) begin
            m = model(4'(a), 4'(b), cc[0], cc[1], 2'(op));
            issue("exh_", 1, 4'(a), 4'(b), cc[0], cc[1], 2'(op), m[3:0], m[4]);
          end

    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: %0d results outstanding expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
